// File: rtl/port_capture.sv
// port_capture: watches the CPU's 8-bit output port and queues every sampled
// change together with a free-running cycle timestamp. A consumer drains the
// queue through a valid/ready handshake. A sticky flag records dropped events.
module port_capture #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               port,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [TS_W-1:0]          out_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]      prev;
  logic            armed;
  logic [TS_W-1:0] ts;

  logic [7:0]      mem_data [DEPTH];
  logic [TS_W-1:0] mem_time [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic change;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;

  // Event detection and queue admission; a full queue still accepts a push
  // when the head leaves on the same edge.
  always_comb begin
    change  = armed && (port != prev);
    full    = (count == CW'(DEPTH));
    pop     = out_valid && out_ready;
    push_ok = change && (!full || pop);
    drop    = change && full && !pop;
  end

  // Sampler state: timestamp counter, previous sample and the arm bit that
  // suppresses an event on the first edge after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts    <= '0;
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      ts    <= ts + TS_W'(1);
      prev  <= port;
      armed <= 1'b1;
    end
  end

  // Queue control: pointers, occupancy and the sticky overflow flag, where a
  // drop on the same edge as clear_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Queue storage; data only, written with the pre-increment timestamp.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_data[wr_ptr] <= port;
      mem_time[wr_ptr] <= ts;
    end
  end

  // Head entry is presented combinationally and forced to zero while empty.
  always_comb begin
    out_valid = (count != '0);
    out_data  = out_valid ? mem_data[rd_ptr] : 8'h00;
    out_time  = out_valid ? mem_time[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_port_capture.sv
// Directed bench for port_capture with hand-computed expected values.
module tb_port_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_time;
  logic [3:0]  count;
  logic        overflow;
  logic        clear_ovf;

  int checks = 0;
  int errors = 0;

  port_capture #(.DEPTH(8), .TS_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .port      (port),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_time  (out_time),
    .count     (count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] pval);
    reset = 1'b0;
    port  = pval;
    step();
    reset = 1'b1;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] d, input logic [15:0] t);
    chk_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk_eq({tag, "_data"},  32'(out_data),  32'(d));
    chk_eq({tag, "_time"},  32'(out_time),  32'(t));
  endtask

  initial begin
    reset = 1'b0; port = 8'h00; out_ready = 1'b0; clear_ovf = 1'b0;

    // Reset state and idle port
    step();
    do_reset(8'h00);
    chk_eq("rst_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_count", 32'(count), 32'd0);
    chk_eq("rst_ovf",   32'(overflow), 32'd0);
    chk_eq("rst_data",  32'(out_data), 32'd0);
    chk_eq("rst_time",  32'(out_time), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_eq("idle_valid", 32'(out_valid), 32'd0);
      chk_eq("idle_count", 32'(count), 32'd0);
      chk_eq("idle_ovf",   32'(overflow), 32'd0);
    end

    // First sample only arms; change at 4th edge carries time 3
    do_reset(8'h5A);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_eq("arm_valid", 32'(out_valid), 32'd0);
    end
    port = 8'h5B;
    step();
    chk_head("evt1", 8'h5B, 16'd3);
    chk_eq("evt1_count", 32'(count), 32'd1);
    step();
    chk_eq("evt1_pop_count", 32'(count), 32'd0);
    step();
    chk_eq("evt1_once_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Consecutive changes, head stability, ordered drain
    do_reset(8'h00);
    step();
    step();
    port = 8'h01; step();
    port = 8'h02; step();
    port = 8'h03; step();
    chk_eq("seq_count", 32'(count), 32'd3);
    chk_head("seq_hold0", 8'h01, 16'd2);
    step();
    chk_head("seq_hold1", 8'h01, 16'd2);
    chk_eq("seq_hold_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    chk_head("seq_d0", 8'h01, 16'd2); step();
    chk_head("seq_d1", 8'h02, 16'd3); step();
    chk_head("seq_d2", 8'h03, 16'd4); step();
    chk_eq("seq_empty_count", 32'(count), 32'd0);
    step();
    chk_eq("empty_ready_count", 32'(count), 32'd0);
    chk_eq("empty_ready_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Overflow: ten changes into depth 8; last drop coincides with clear_ovf
    do_reset(8'h00);
    step();
    for (int i = 1; i <= 10; i++) begin
      port = 8'(8'h10 + i);
      clear_ovf = (i == 10);
      step();
      if (i == 8) chk_eq("ovf_pre", 32'(overflow), 32'd0);
    end
    clear_ovf = 1'b0;
    chk_eq("ovf_count", 32'(count), 32'd8);
    chk_eq("ovf_set_wins", 32'(overflow), 32'd1);
    chk_head("ovf_head", 8'h11, 16'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk_eq("ovf_cleared", 32'(overflow), 32'd0);
    chk_eq("ovf_clr_count", 32'(count), 32'd8);

    // Full queue with simultaneous push and pop (edge 13, ts 12)
    port = 8'hAA;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_eq("fullpp_count", 32'(count), 32'd8);
    chk_eq("fullpp_ovf",   32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      chk_head("full_drain", 8'(8'h10 + i), 16'(i));
      step();
    end
    chk_head("full_last", 8'hAA, 16'd12);
    step();
    chk_eq("full_drained", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Reset mid-operation discards entries and restarts the timestamp
    do_reset(8'h00);
    step();
    port = 8'h21; step();
    port = 8'h22; step();
    port = 8'h23; step();
    chk_eq("mid_count", 32'(count), 32'd3);
    reset = 1'b0;
    port = 8'h30;
    step();
    chk_eq("mid_rst_count", 32'(count), 32'd0);
    chk_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    chk_eq("mid_rst_data",  32'(out_data), 32'd0);
    reset = 1'b1;
    step();
    chk_eq("mid_arm_valid", 32'(out_valid), 32'd0);
    port = 8'h31;
    step();
    chk_head("mid_evt", 8'h31, 16'd1);
    chk_eq("mid_evt_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_capture.md
# port_capture

Observer for the CPU's 8-bit output port. Every cycle it compares the sampled `port` value with the previous sample. On each change it pushes the new value and a free-running cycle timestamp into an internal FIFO. A bench or host drains the FIFO through a valid/ready handshake, so port writes are checked as ordered, timed events rather than by waveform inspection.

## Interface
Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2.
- TS_W, 16, timestamp width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- port  in  8  CPU output port, sampled on every rising edge.
- out_valid  out  1  FIFO head holds an entry.
- out_ready  in  1  consumer accepts the head entry when out_valid is also high.
- out_data  out  8  port value of the head entry.
- out_time  out  TS_W  timestamp of the head entry.
- count  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky flag: at least one change was dropped because the FIFO was full.
- clear_ovf  in  1  clears overflow.

## Operation
Registers:
- prev: the last sampled `port` value.
- armed: 1 bit.
- ts: TS_W-bit counter.
- FIFO: DEPTH entries of {data[7:0], time[TS_W-1:0]}, with read/write pointers and a count.

Reset (reset==0 at an edge):
- ts=0, prev=0, armed=0.
- Pointers=0, count=0, overflow=0.
- out_valid=0; out_data and out_time read as 0 while empty.
- A reset mid-operation discards all stored entries. No push happens in a reset cycle.

Each non-reset edge:
- ts <= ts+1, wrapping modulo 2^TS_W with no flag.
- prev <= port.
- armed <= 1.

Change detect:
- change = armed && (port != prev).
- The first edge after reset only loads prev. It never produces an event, even if port≠0.

Push:
- On change, the entry {port, ts} is written, using the ts value before this edge's increment.

Pop:
- pop = out_valid && out_ready; it advances the read pointer.

Full / empty rules:
- Push while count==DEPTH and no pop: entry dropped, count unchanged, overflow <= 1.
- Push and pop on the same edge while full: both succeed, count stays DEPTH, no overflow.
- Push and pop on the same edge with 0<count<DEPTH: count unchanged, order preserved.
- out_ready while empty: ignored, count stays 0.

Overflow flag:
- clear_ovf=1 clears overflow on that edge.
- If a drop happens on the same edge, set wins and overflow stays 1.

Outputs:
- out_valid = (count != 0).
- out_data and out_time come straight from the head entry, with no extra register stage.
- Pointers wrap modulo DEPTH; count is kept separately so full and empty are unambiguous.

## Timing
- Event latency: a port value that first differs at edge k is visible with out_valid=1 immediately after edge k, with out_time equal to ts sampled at edge k.
- Throughput: one push and one pop per cycle. Back-to-back port changes on consecutive edges each produce one entry.
- Glitches shorter than one clock period are not seen; only edge-sampled values count.
- Head stability: out_data and out_time stay stable while out_valid=1 and out_ready=0.
- Reset release: ts=0 at the first edge with reset==1, so that edge's sample carries time 0 (it only arms).

## Test plan
- Reset, then port held at 0x00 for 20 cycles → out_valid=0, count=0, overflow=0 throughout.
- Release reset with port=0x5A, then port=0x5B at the 4th edge after release, out_ready=1 → exactly one entry: out_data=0x5B, out_time=3. The initial 0x5A produces no event.
- port steps 0x01,0x02,0x03 on consecutive edges with out_ready=0 → count=3. Draining yields data 01,02,03 in order with consecutive timestamps.
- DEPTH=8, out_ready=0, ten distinct changes → count=8, overflow=1, and the stored entries are the first eight. Then clear_ovf=1 for one cycle with no new change → overflow=0.
- Full FIFO, out_ready=1 and a port change on the same edge → count stays 8, overflow stays 0, and the new value appears as the last entry when drained.
- With 3 entries stored, reset=0 for one edge → count=0, out_valid=0, ts restarts. After release, the first change is timestamped relative to the new origin.
